// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_if
// Description : Bus bundle for the memory-access pipeline stage. Carries the
//               execute->memory handshake and bus, the SRAM read data, the
//               memory->write-back handshake and bus, and the ID bypass bus.
//   slave  : the memory stage itself
//   master : the surrounding pipeline (execute, SRAM, write-back, ID)
// Ports       : exe_to_mem_valid, exe_to_mem_bus, data_sram_rdata,
//               wb_allow_in (into the stage); mem_allow_in, mem_to_wb_valid,
//               mem_to_wb_bus, mem_valid, mem_to_id_bypass_bus (out of it)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if #(
  parameter int PC_W    = 32,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);
  localparam int ES_BUS_W = PC_W + DATA_W + 3 + 1 + 1 + RADDR_W;
  localparam int WB_BUS_W = PC_W + DATA_W + 1 + RADDR_W;
  localparam int BP_BUS_W = 1 + RADDR_W + DATA_W;

  logic                exe_to_mem_valid;
  logic                mem_allow_in;
  logic [ES_BUS_W-1:0] exe_to_mem_bus;
  logic [DATA_W-1:0]   data_sram_rdata;
  logic                wb_allow_in;
  logic                mem_to_wb_valid;
  logic [WB_BUS_W-1:0] mem_to_wb_bus;
  logic                mem_valid;
  logic [BP_BUS_W-1:0] mem_to_id_bypass_bus;

  modport slave (
    input  exe_to_mem_valid, exe_to_mem_bus, data_sram_rdata, wb_allow_in,
    output mem_allow_in, mem_to_wb_valid, mem_to_wb_bus, mem_valid,
           mem_to_id_bypass_bus
  );

  modport master (
    output exe_to_mem_valid, exe_to_mem_bus, data_sram_rdata, wb_allow_in,
    input  mem_allow_in, mem_to_wb_valid, mem_to_wb_bus, mem_valid,
           mem_to_id_bypass_bus
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage. Registers the execute bus,
//               aligns/extends SRAM load data, selects the final result and
//               forwards it to write-back and the ID bypass network. SRAM
//               read data is buffered while write-back stalls, because the
//               SRAM only presents it for one cycle.
// Ports       : clk     - clock
//               resetn  - synchronous active-low reset
//               mem_if  - mem_stage_if.slave bundle (handshakes and buses)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int PC_W    = 32,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic          clk,
  input  logic          resetn,
  mem_stage_if.slave    mem_if
);

  localparam int BUS_W   = PC_W + DATA_W + 3 + 1 + 1 + RADDR_W;
  // Field positions inside {pc, alu_result, ld_op, res_from_mem, reg_we, waddr}
  localparam int WE_BIT  = RADDR_W;
  localparam int RFM_BIT = RADDR_W + 1;
  localparam int OP_LSB  = RADDR_W + 2;
  localparam int ALU_LSB = RADDR_W + 5;
  localparam int PC_LSB  = ALU_LSB + DATA_W;

  logic              r_valid;
  logic [BUS_W-1:0]  r_bus;
  logic              r_rdata_held;
  logic [DATA_W-1:0] r_rdata_buf;

  logic              w_allow;
  logic              w_accept;
  logic              w_capture;
  logic [PC_W-1:0]   w_pc;
  logic [DATA_W-1:0] w_alu;
  logic [2:0]        w_ld_op;
  logic              w_rfm;
  logic              w_we;
  logic [RADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_raw;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_final;

  assign w_allow  = !r_valid || mem_if.wb_allow_in;
  assign w_accept = w_allow && mem_if.exe_to_mem_valid;
  // First stalled cycle of a load: the SRAM data disappears next cycle, so
  // keep a copy. Only possible while write-back blocks, hence never together
  // with w_accept.
  assign w_capture = r_valid && w_rfm && !mem_if.wb_allow_in && !r_rdata_held;

  assign w_pc    = r_bus[PC_LSB +: PC_W];
  assign w_alu   = r_bus[ALU_LSB +: DATA_W];
  assign w_ld_op = r_bus[OP_LSB +: 3];
  assign w_rfm   = r_bus[RFM_BIT];
  assign w_we    = r_bus[WE_BIT];
  assign w_waddr = r_bus[RADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= 1'b0;
    end else if (w_allow) begin
      r_valid <= mem_if.exe_to_mem_valid;
    end
  end

  // Payload needs no reset: every output derived from it is qualified by r_valid
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_bus <= mem_if.exe_to_mem_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rdata_held <= 1'b0;
    end else if (w_accept) begin
      r_rdata_held <= 1'b0;
    end else if (w_capture) begin
      r_rdata_held <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_rdata_buf <= mem_if.data_sram_rdata;
    end
  end

  assign w_raw  = r_rdata_held ? r_rdata_buf : mem_if.data_sram_rdata;
  // Misaligned accesses are not trapped: a[0] is ignored for halfwords
  assign w_half = w_alu[1] ? w_raw[31:16] : w_raw[15:0];

  always_comb begin
    w_byte = w_raw[7:0];
    case (w_alu[1:0])
      2'd1:    w_byte = w_raw[15:8];
      2'd2:    w_byte = w_raw[23:16];
      2'd3:    w_byte = w_raw[31:24];
      default: w_byte = w_raw[7:0];
    endcase
  end

  always_comb begin
    w_load = w_raw;
    case (w_ld_op)
      3'b001:  w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
      3'b010:  w_load = {{(DATA_W-8){1'b0}}, w_byte};
      3'b011:  w_load = {{(DATA_W-16){w_half[15]}}, w_half};
      3'b100:  w_load = {{(DATA_W-16){1'b0}}, w_half};
      default: w_load = w_raw;
    endcase
  end

  assign w_final = w_rfm ? w_load : w_alu;

  assign mem_if.mem_allow_in         = w_allow;
  assign mem_if.mem_valid            = r_valid;
  assign mem_if.mem_to_wb_valid      = r_valid;
  assign mem_if.mem_to_wb_bus        = {w_pc, w_final, w_we, w_waddr};
  assign mem_if.mem_to_id_bypass_bus = {w_we & r_valid, w_waddr, w_final};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard bench for mem_stage. Stimulus pushes hand-computed
//               expected results as instructions are accepted; a monitor on
//               the falling edge pops and compares on each write-back
//               transfer and checks result stability during stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
    logic        we;
    logic [4:0]  wa;
  } exp_t;

  logic clk;
  logic resetn;
  logic mon_on;
  logic model_valid;
  int   total;
  int   bad;
  exp_t q[$];
  exp_t m_e;

  mem_stage_if #(.PC_W(32), .DATA_W(32), .RADDR_W(5)) u_if ();

  mem_stage #(.PC_W(32), .DATA_W(32), .RADDR_W(5)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .mem_if (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock cycle. rd is the SRAM data visible this cycle, i.e. the data
  // for the instruction already sitting in the stage.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                     input logic [2:0] op, input logic rfm, input logic we,
                     input logic [4:0] wa, input logic [31:0] ex,
                     input logic [31:0] rd, input logic wba);
    logic allow;
    exp_t e;
    u_if.exe_to_mem_valid = v;
    u_if.exe_to_mem_bus   = {pc, alu, op, rfm, we, wa};
    u_if.data_sram_rdata  = rd;
    u_if.wb_allow_in      = wba;
    #1;
    allow = !model_valid || wba;
    if (mon_on) chk("allow_in", {69'd0, u_if.mem_allow_in}, {69'd0, allow});
    @(posedge clk);
    if (!resetn) begin
      model_valid = 1'b0;
      q.delete();
    end else if (allow) begin
      model_valid = v;
      if (v) begin
        e.pc = pc; e.res = ex; e.we = we; e.wa = wa;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] rd, input logic wba);
    cyc(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 5'd0, 32'h0, rd, wba);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("mem_valid", {69'd0, u_if.mem_valid}, {69'd0, model_valid});
      chk("to_wb_valid", {69'd0, u_if.mem_to_wb_valid}, {69'd0, model_valid});
      if (u_if.mem_to_wb_valid === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h want none", u_if.mem_to_wb_bus);
        end else begin
          m_e = q[0];
          if (u_if.wb_allow_in) begin
            chk("wb_bus", u_if.mem_to_wb_bus, {m_e.pc, m_e.res, m_e.we, m_e.wa});
            chk("bypass", {32'd0, u_if.mem_to_id_bypass_bus}, {32'd0, m_e.we, m_e.wa, m_e.res});
            void'(q.pop_front());
          end else begin
            chk("stall_hold", {6'd0, u_if.mem_to_wb_bus[37:6]}, {38'd0, m_e.res});
          end
        end
      end else begin
        chk("bypass_we_idle", {69'd0, u_if.mem_to_id_bypass_bus[37]}, 70'd0);
      end
    end
  end

  initial begin
    total = 0; bad = 0; mon_on = 1'b0; model_valid = 1'b0; resetn = 1'b0;

    // Reset held two cycles with an offer pending
    cyc(1, 32'h100, 32'h12345678, 3'd0, 0, 1, 5'd7, 32'h12345678, 32'h0, 1);
    chk("rst_valid", {69'd0, u_if.mem_valid}, 70'd0);
    chk("rst_wb_valid", {69'd0, u_if.mem_to_wb_valid}, 70'd0);
    chk("rst_bp_we", {69'd0, u_if.mem_to_id_bypass_bus[37]}, 70'd0);
    mon_on = 1'b1;
    cyc(1, 32'h100, 32'h12345678, 3'd0, 0, 1, 5'd7, 32'h12345678, 32'h0, 1);
    resetn = 1'b1;

    // ALU pass-through, accepted on the first edge after release
    cyc(1, 32'h100, 32'h12345678, 3'd0, 0, 1, 5'd7, 32'h12345678, 32'h0, 1);
    // Byte/halfword loads on 0x80FF0011, back to back
    cyc(1, 32'h104, 32'h00001003, 3'd1, 1, 1, 5'd1, 32'hFFFFFF80, 32'h0, 1);
    cyc(1, 32'h108, 32'h00001003, 3'd2, 1, 1, 5'd2, 32'h00000080, 32'h80FF0011, 1);
    cyc(1, 32'h10C, 32'h00001002, 3'd3, 1, 1, 5'd3, 32'hFFFF80FF, 32'h80FF0011, 1);
    cyc(1, 32'h110, 32'h00001002, 3'd4, 1, 1, 5'd4, 32'h000080FF, 32'h80FF0011, 1);
    idle(32'h80FF0011, 1);

    // ld.w stalled 3 cycles while SRAM data changes; an offer during the
    // stall must be ignored
    cyc(1, 32'h200, 32'h00002000, 3'd0, 1, 1, 5'd9, 32'hDEADBEEF, 32'h0, 1);
    idle(32'hDEADBEEF, 0);
    cyc(1, 32'hBAD0, 32'hFFFFFFFF, 3'd0, 0, 1, 5'd31, 32'h0, 32'h0, 0);
    idle(32'h0, 0);
    // Transfer cycle: next load enters as the stalled one leaves
    cyc(1, 32'h204, 32'h00002004, 3'd0, 1, 1, 5'd10, 32'h0000000A, 32'h0, 1);
    cyc(1, 32'h208, 32'h00002008, 3'd0, 1, 1, 5'd11, 32'h0000000B, 32'h0000000A, 1);
    cyc(1, 32'h20C, 32'h0000200C, 3'd0, 1, 1, 5'd12, 32'h0000000C, 32'h0000000B, 1);
    idle(32'h0000000C, 1);

    // Odd ld_op behaves as word; ALU op with reg_we low
    cyc(1, 32'h300, 32'h00003001, 3'd5, 1, 1, 5'd13, 32'hCAFEF00D, 32'h0, 1);
    cyc(1, 32'h304, 32'h00000055, 3'd0, 0, 0, 5'd3, 32'h00000055, 32'hCAFEF00D, 1);
    idle(32'h0, 1);

    // Reset while a load is stalled with its data buffered
    cyc(1, 32'h400, 32'h00004000, 3'd0, 1, 1, 5'd14, 32'h11111111, 32'h0, 1);
    idle(32'h11111111, 0);
    idle(32'h0, 0);
    resetn = 1'b0;
    idle(32'h0, 0);
    chk("midrst_valid", {69'd0, u_if.mem_valid}, 70'd0);
    resetn = 1'b1;
    cyc(1, 32'h500, 32'h00005000, 3'd0, 1, 1, 5'd15, 32'h22222222, 32'h0, 1);
    idle(32'h22222222, 1);
    idle(32'h0, 1);
    idle(32'h0, 1);

    chk("queue_drained", {38'd0, 32'(q.size())}, 70'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
